// File: rtl/m_mem_arb.sv
// m_mem_arb: two-port arbiter/sequencer sharing one handshaked memory
// between the core's instruction-fetch port (i) and data port (d).
// One memory transaction outstanding at a time; FSM IDLE -> WAIT -> RESP.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin on conflict (1-bit last-granted pointer)
//   undefined : fixed priority, data port always wins a conflict
//
// Handshake: a port holds *_req with its address/we/wdata stable until its
// one-cycle *_oe pulse; on the memory side w_m_req is held with stable
// w_m_* until the one-cycle w_m_ack. Acks outside WAIT are ignored.
// w_state exposes the FSM state (IDLE=0, WAIT=1, RESP=2) for debug.
module m_mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_i_req,
    input  logic [AW-1:0] w_i_addr,
    output logic [DW-1:0] w_i_rdata,
    output logic          w_i_oe,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_wdata,
    output logic [DW-1:0] w_d_rdata,
    output logic          w_d_oe,
    output logic          w_m_req,
    output logic          w_m_we,
    output logic [AW-1:0] w_m_addr,
    output logic [DW-1:0] w_m_wdata,
    input  logic [DW-1:0] w_m_rdata,
    input  logic          w_m_ack,
    output logic [CW-1:0] w_i_cnt,
    output logic [CW-1:0] w_d_cnt,
    output logic [1:0]    w_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic       owner;
    logic       any_req;
    logic       grant_d;

`ifdef MEM_ARB_RR_EN
    // Last granted port; reset value OWN_I so data wins the first conflict.
    logic rr_ptr;

    // Round-robin: data wins if alone, or on conflict when fetch was last granted.
    always_comb begin
        any_req = w_i_req || w_d_req;
        grant_d = w_d_req && (!w_i_req || (rr_ptr == OWN_I));
    end

    // Pointer follows every grant taken in IDLE.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            rr_ptr <= OWN_I;
        end else if ((state == S_IDLE) && any_req) begin
            rr_ptr <= grant_d;
        end
    end
`else
    // Fixed priority: any data request beats a fetch request.
    always_comb begin
        any_req = w_i_req || w_d_req;
        grant_d = w_d_req;
    end
`endif

    assign w_state = state;

    // Sequencer: grant in IDLE, hold memory request until ack, pulse oe in RESP.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state     <= S_IDLE;
            owner     <= OWN_I;
            w_m_req   <= 1'b0;
            w_m_we    <= 1'b0;
            w_m_addr  <= '0;
            w_m_wdata <= '0;
            w_i_rdata <= '0;
            w_d_rdata <= '0;
            w_i_oe    <= 1'b0;
            w_d_oe    <= 1'b0;
            w_i_cnt   <= '0;
            w_d_cnt   <= '0;
        end else begin
            // oe pulses last exactly one cycle (the RESP cycle)
            w_i_oe <= 1'b0;
            w_d_oe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner   <= grant_d;
                        w_m_req <= 1'b1;
                        if (grant_d) begin
                            w_m_addr  <= w_d_addr;
                            w_m_we    <= w_d_we;
                            w_m_wdata <= w_d_wdata;
                        end else begin
                            // fetches are always reads
                            w_m_addr  <= w_i_addr;
                            w_m_we    <= 1'b0;
                            w_m_wdata <= '0;
                        end
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_m_ack) begin
                        w_m_req <= 1'b0;
                        w_m_we  <= 1'b0;
                        if (owner == OWN_D) begin
                            // a store returns 0 to the data port
                            w_d_rdata <= w_m_we ? '0 : w_m_rdata;
                            w_d_oe    <= 1'b1;
                            w_d_cnt   <= w_d_cnt + CNT_ONE;
                        end else begin
                            w_i_rdata <= w_m_rdata;
                            w_i_oe    <= 1'b1;
                            w_i_cnt   <= w_i_cnt + CNT_ONE;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // requests are not sampled here; requester updates them now
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_arb.sv
// Directed testbench for m_mem_arb. A behavioural memory with configurable
// ack latency (mem_k) answers w_m_req; each test task drives its stimulus
// and compares DUT outputs against hand-computed values.
module tb_m_mem_arb;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_oe;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_oe;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic [31:0] i_cnt;
    logic [31:0] d_cnt;
    logic [1:0]  state;

    int n_cmp  = 0;
    int n_fail = 0;
    int mem_k  = 1;

    logic [31:0] exp_q[$];

    m_mem_arb #(.AW(32), .DW(32), .CW(32)) dut (
        .w_clk     (clk),
        .w_rst_n   (rst_n),
        .w_i_req   (i_req),
        .w_i_addr  (i_addr),
        .w_i_rdata (i_rdata),
        .w_i_oe    (i_oe),
        .w_d_req   (d_req),
        .w_d_we    (d_we),
        .w_d_addr  (d_addr),
        .w_d_wdata (d_wdata),
        .w_d_rdata (d_rdata),
        .w_d_oe    (d_oe),
        .w_m_req   (m_req),
        .w_m_we    (m_we),
        .w_m_addr  (m_addr),
        .w_m_wdata (m_wdata),
        .w_m_rdata (m_rdata),
        .w_m_ack   (m_ack),
        .w_i_cnt   (i_cnt),
        .w_d_cnt   (d_cnt),
        .w_state   (state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory model: sees w_m_req, acks mem_k cycles later for one cycle
    initial begin
        logic [31:0] mem [logic [31:0]];
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic        r_we;
        mem[32'h0000_0000] = 32'h0000_0013;
        mem[32'h0000_0004] = 32'h0010_0093;
        mem[32'h0000_0008] = 32'h0020_0113;
        mem[32'h0000_0010] = 32'h0050_0093;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (m_req) begin
                r_addr  = m_addr;
                r_we    = m_we;
                r_wdata = m_wdata;
                repeat (mem_k) @(posedge clk);
                #1;
                m_ack = 1'b1;
                if (r_we) begin
                    m_rdata = 32'hA5A5_A5A5;
                    mem[r_addr] = r_wdata;
                end else begin
                    m_rdata = mem.exists(r_addr) ? mem[r_addr] : 32'h0;
                end
                @(posedge clk); #1;
                m_ack   = 1'b0;
                m_rdata = '0;
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (state   !== ST_IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", state, ST_IDLE); end
        n_cmp++; if (m_req   !== 1'b0)    begin n_fail++; $display("FAIL rst_m_req got=%b exp=0", m_req); end
        n_cmp++; if (m_we    !== 1'b0)    begin n_fail++; $display("FAIL rst_m_we got=%b exp=0", m_we); end
        n_cmp++; if (m_addr  !== 32'h0)   begin n_fail++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
        n_cmp++; if (m_wdata !== 32'h0)   begin n_fail++; $display("FAIL rst_m_wdata got=%h exp=0", m_wdata); end
        n_cmp++; if (i_oe    !== 1'b0)    begin n_fail++; $display("FAIL rst_i_oe got=%b exp=0", i_oe); end
        n_cmp++; if (d_oe    !== 1'b0)    begin n_fail++; $display("FAIL rst_d_oe got=%b exp=0", d_oe); end
        n_cmp++; if (i_rdata !== 32'h0)   begin n_fail++; $display("FAIL rst_i_rdata got=%h exp=0", i_rdata); end
        n_cmp++; if (d_rdata !== 32'h0)   begin n_fail++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
        n_cmp++; if (i_cnt   !== 32'h0)   begin n_fail++; $display("FAIL rst_i_cnt got=%0d exp=0", i_cnt); end
        n_cmp++; if (d_cnt   !== 32'h0)   begin n_fail++; $display("FAIL rst_d_cnt got=%0d exp=0", d_cnt); end
    endtask

    task automatic test_single_fetch();
        mem_k = 1;
        cycle();                         // cycle t: request sampled at its end
        i_req  = 1'b1;
        i_addr = 32'h0000_0010;
        cycle();                         // t+1
        n_cmp++; if (m_req  !== 1'b1)         begin n_fail++; $display("FAIL sf_m_req got=%b exp=1", m_req); end
        n_cmp++; if (m_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL sf_m_addr got=%h exp=00000010", m_addr); end
        n_cmp++; if (m_we   !== 1'b0)         begin n_fail++; $display("FAIL sf_m_we got=%b exp=0", m_we); end
        n_cmp++; if (state  !== ST_WAIT)      begin n_fail++; $display("FAIL sf_state_wait got=%0d exp=%0d", state, ST_WAIT); end
        cycle();                         // t+2: ack on the bus
        n_cmp++; if (i_oe   !== 1'b0)         begin n_fail++; $display("FAIL sf_early_oe got=%b exp=0", i_oe); end
        cycle();                         // t+3
        n_cmp++; if (i_oe    !== 1'b1)         begin n_fail++; $display("FAIL sf_i_oe got=%b exp=1", i_oe); end
        n_cmp++; if (i_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL sf_i_rdata got=%h exp=00500093", i_rdata); end
        n_cmp++; if (i_cnt   !== 32'd1)        begin n_fail++; $display("FAIL sf_i_cnt got=%0d exp=1", i_cnt); end
        n_cmp++; if (d_oe    !== 1'b0)         begin n_fail++; $display("FAIL sf_d_oe got=%b exp=0", d_oe); end
        n_cmp++; if (m_req   !== 1'b0)         begin n_fail++; $display("FAIL sf_m_req_drop got=%b exp=0", m_req); end
        n_cmp++; if (state   !== ST_RESP)      begin n_fail++; $display("FAIL sf_state_resp got=%0d exp=%0d", state, ST_RESP); end
        i_req = 1'b0;
        cycle();                         // t+4
        n_cmp++; if (i_oe    !== 1'b0)         begin n_fail++; $display("FAIL sf_oe_width got=%b exp=0", i_oe); end
        n_cmp++; if (state   !== ST_IDLE)      begin n_fail++; $display("FAIL sf_state_idle got=%0d exp=%0d", state, ST_IDLE); end
        n_cmp++; if (i_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL sf_i_rdata_hold got=%h exp=00500093", i_rdata); end
    endtask

    task automatic test_store_load();
        mem_k = 1;
        cycle();                         // t: store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        cycle();                         // t+1
        n_cmp++; if (m_we    !== 1'b1)         begin n_fail++; $display("FAIL st_m_we got=%b exp=1", m_we); end
        n_cmp++; if (m_addr  !== 32'h0000_0100) begin n_fail++; $display("FAIL st_m_addr got=%h exp=00000100", m_addr); end
        n_cmp++; if (m_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_m_wdata got=%h exp=deadbeef", m_wdata); end
        cycle();                         // t+2: ack
        n_cmp++; if (m_we    !== 1'b1)         begin n_fail++; $display("FAIL st_m_we_hold got=%b exp=1", m_we); end
        cycle();                         // t+3
        n_cmp++; if (d_oe    !== 1'b1)         begin n_fail++; $display("FAIL st_d_oe got=%b exp=1", d_oe); end
        n_cmp++; if (d_rdata !== 32'h0)        begin n_fail++; $display("FAIL st_d_rdata got=%h exp=0", d_rdata); end
        n_cmp++; if (m_we    !== 1'b0)         begin n_fail++; $display("FAIL st_m_we_drop got=%b exp=0", m_we); end
        n_cmp++; if (d_cnt   !== 32'd1)        begin n_fail++; $display("FAIL st_d_cnt got=%0d exp=1", d_cnt); end
        d_we = 1'b0;                     // next transaction: load same address
        cycle();                         // t+4: IDLE samples load
        cycle();                         // t+5
        n_cmp++; if (m_we    !== 1'b0)         begin n_fail++; $display("FAIL ld_m_we got=%b exp=0", m_we); end
        n_cmp++; if (m_req   !== 1'b1)         begin n_fail++; $display("FAIL ld_m_req got=%b exp=1", m_req); end
        cycle();                         // t+6: ack
        cycle();                         // t+7
        n_cmp++; if (d_oe    !== 1'b1)         begin n_fail++; $display("FAIL ld_d_oe got=%b exp=1", d_oe); end
        n_cmp++; if (d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_d_rdata got=%h exp=deadbeef", d_rdata); end
        n_cmp++; if (d_cnt   !== 32'd2)        begin n_fail++; $display("FAIL ld_d_cnt got=%0d exp=2", d_cnt); end
        n_cmp++; if (i_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL ld_i_rdata_keep got=%h exp=00500093", i_rdata); end
        n_cmp++; if (i_cnt   !== 32'd1)        begin n_fail++; $display("FAIL ld_i_cnt_keep got=%0d exp=1", i_cnt); end
        d_req = 1'b0;
    endtask

    task automatic test_conflict();
        logic [3:0] got;
        logic [3:0] exp_order;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        int n;
        int cyc;
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b0101;             // bit n = port of nth grant (1=D): D,I,D,I
        exp_i = 32'd2;
        exp_d = 32'd2;
`else
        exp_order = 4'b1111;             // D,D,D,D
        exp_i = 32'd0;
        exp_d = 32'd4;
`endif
        do_reset();
        mem_k = 1;
        got   = 4'b0000;
        i_req  = 1'b1;
        i_addr = 32'h0000_0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0100;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            cycle();
            cyc++;
            if (d_oe) begin
                got[n] = 1'b1;
                n++;
            end else if (i_oe) begin
                got[n] = 1'b0;
                n++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        n_cmp++; if (n     !== 4)         begin n_fail++; $display("FAIL cf_done got=%0d exp=4", n); end
        n_cmp++; if (got   !== exp_order) begin n_fail++; $display("FAIL cf_order got=%b exp=%b", got, exp_order); end
        n_cmp++; if (i_cnt !== exp_i)     begin n_fail++; $display("FAIL cf_i_cnt got=%0d exp=%0d", i_cnt, exp_i); end
        n_cmp++; if (d_cnt !== exp_d)     begin n_fail++; $display("FAIL cf_d_cnt got=%0d exp=%0d", d_cnt, exp_d); end
        n_cmp++; if (d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cf_d_rdata got=%h exp=deadbeef", d_rdata); end
    endtask

    task automatic test_reset_mid();
        bit seen_oe;
        bit left_idle;
        mem_k = 5;
        cycle();                         // t
        i_req  = 1'b1;
        i_addr = 32'h0000_0010;
        cycle();                         // t+1
        n_cmp++; if (state !== ST_WAIT) begin n_fail++; $display("FAIL rm_state_wait got=%0d exp=%0d", state, ST_WAIT); end
        cycle();                         // t+2: reset during WAIT
        rst_n = 1'b0;
        i_req = 1'b0;
        cycle();                         // t+3
        cycle();                         // t+4: release, ack arrives at t+6
        rst_n = 1'b1;
        n_cmp++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL rm_state_rst got=%0d exp=%0d", state, ST_IDLE); end
        n_cmp++; if (m_req !== 1'b0)    begin n_fail++; $display("FAIL rm_m_req got=%b exp=0", m_req); end
        seen_oe   = 1'b0;
        left_idle = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (i_oe || d_oe) seen_oe = 1'b1;
            if (state !== ST_IDLE) left_idle = 1'b1;
        end
        n_cmp++; if (seen_oe   !== 1'b0) begin n_fail++; $display("FAIL rm_oe got=%b exp=0", seen_oe); end
        n_cmp++; if (left_idle !== 1'b0) begin n_fail++; $display("FAIL rm_idle got=%b exp=0", left_idle); end
        n_cmp++; if (i_cnt !== 32'd0)    begin n_fail++; $display("FAIL rm_i_cnt got=%0d exp=0", i_cnt); end
        n_cmp++; if (d_cnt !== 32'd0)    begin n_fail++; $display("FAIL rm_d_cnt got=%0d exp=0", d_cnt); end
    endtask

    task automatic test_back_to_back();
        int pulse_cyc[3];
        int n;
        int cyc;
        logic [31:0] exp_data;
        exp_q.push_back(32'h0000_0013);
        exp_q.push_back(32'h0010_0093);
        exp_q.push_back(32'h0020_0113);
        mem_k = 1;
        cycle();
        i_req  = 1'b1;
        i_addr = 32'h0000_0000;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 40) begin
            cycle();
            cyc++;
            if (i_oe) begin
                exp_data = exp_q.pop_front();
                n_cmp++; if (i_rdata !== exp_data) begin n_fail++; $display("FAIL bb_rdata%0d got=%h exp=%h", n, i_rdata, exp_data); end
                pulse_cyc[n] = cyc;
                n++;
                i_addr = i_addr + 32'd4;
                if (n == 3) i_req = 1'b0;
            end
        end
        i_req = 1'b0;
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL bb_done got=%0d exp=3", n); end
        if (n == 3) begin
            n_cmp++; if (pulse_cyc[0] !== 3) begin n_fail++; $display("FAIL bb_first got=%0d exp=3", pulse_cyc[0]); end
            n_cmp++; if (pulse_cyc[1] - pulse_cyc[0] !== 4) begin n_fail++; $display("FAIL bb_gap1 got=%0d exp=4", pulse_cyc[1] - pulse_cyc[0]); end
            n_cmp++; if (pulse_cyc[2] - pulse_cyc[1] !== 4) begin n_fail++; $display("FAIL bb_gap2 got=%0d exp=4", pulse_cyc[2] - pulse_cyc[1]); end
        end
        n_cmp++; if (i_cnt !== 32'd3) begin n_fail++; $display("FAIL bb_i_cnt got=%0d exp=3", i_cnt); end
        n_cmp++; if (d_cnt !== 32'd0) begin n_fail++; $display("FAIL bb_d_cnt got=%0d exp=0", d_cnt); end
        exp_q.delete();
    endtask

    // main sequence
    initial begin
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_conflict();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/m_mem_arb.md
# m_mem_arb

Two-port arbiter and sequencer that shares one single-ported, handshaked memory between the pipelined core's instruction-fetch port and data (load/store) port. It replaces the direct core-to-`m_imem` connection. Each port's one-cycle `*_oe` pulse is what the core's stall logic consumes, in the same way `w_stall = !w_oe` is used today. The block holds one outstanding memory transaction at a time and counts grants per port for simulation `$display` traces.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `CW`, 32: width of the grant counters.
- `w_clk` in 1: clock; all state updates on the rising edge.
- `w_rst_n` in 1: reset, synchronous, active-low.
- `w_i_req` in 1: fetch request; held high with `w_i_addr` stable until `w_i_oe`.
- `w_i_addr` in AW: fetch address.
- `w_i_rdata` out DW: fetched instruction; valid when `w_i_oe`=1.
- `w_i_oe` out 1: one-cycle fetch-complete pulse.
- `w_d_req` in 1: data request; held high with addr/we/wdata stable until `w_d_oe`.
- `w_d_we` in 1: 1 = store, 0 = load.
- `w_d_addr` in AW: data address.
- `w_d_wdata` in DW: store data.
- `w_d_rdata` out DW: load data; valid when `w_d_oe`=1.
- `w_d_oe` out 1: one-cycle data-complete pulse (loads and stores).
- `w_m_req` out 1: memory request; held high until `w_m_ack`.
- `w_m_we` out 1: memory write enable.
- `w_m_addr` out AW: memory address.
- `w_m_wdata` out DW: memory write data.
- `w_m_rdata` in DW: memory read data; valid with `w_m_ack`.
- `w_m_ack` in 1: one-cycle completion from memory; only legal while `w_m_req`=1.
- `w_i_cnt`, `w_d_cnt` out CW: completed-transaction counters per port.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. All outputs are driven from registers.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: arbitration picks the winner (see Configuration).
  - On grant, latch owner, addr, we and wdata into the memory-side registers, set `w_m_req`=1 and go to WAIT.
  - A fetch grant always forces `w_m_we`=0.
- **WAIT**
  - Hold `w_m_*` stable.
  - On `w_m_ack`:
    - Drop `w_m_req`.
    - Capture `w_m_rdata` into the owner's rdata register. For a store, the owner's rdata register loads 0.
    - Raise the owner's `*_oe`.
    - Increment the owner's counter, wrapping modulo 2^CW.
    - Go to RESP.
- **RESP**
  - `*_oe` is high for exactly this cycle.
  - Requests are ignored; go to IDLE.
- The non-owner's rdata register is unchanged.
- Each rdata register holds its value until that port's next completion.
- Only one transaction is outstanding. A request arriving during WAIT or RESP waits, and the requester keeps `*_req` asserted.
- Reset (`w_rst_n`=0 at a clock edge), in any state:
  - State goes to IDLE.
  - `w_m_req`, `w_m_we`, `w_i_oe` and `w_d_oe` go to 0.
  - `w_m_addr`, `w_m_wdata`, `w_i_rdata` and `w_d_rdata` go to 0.
  - Both counters go to 0.
  - The round-robin pointer points at the fetch port, so the data port wins the first conflict after reset.
- An in-flight transaction is abandoned. Any `w_m_ack` seen while not in WAIT is ignored.

## Timing
- Request sampled in IDLE at edge of cycle t:
  - `w_m_req`=1 in cycle t+1.
  - Memory with ack latency k≥1 cycles after seeing the request: `w_m_ack` in cycle t+k+1.
  - `*_oe`=1 in cycle t+k+2.
  - IDLE again in cycle t+k+3.
- Minimum turnaround: 4 cycles per transaction (k=1). That is the next grant at t+4 when the next request is present at t+3.
- Requester rule: in the cycle after `*_oe`, deassert `*_req` or present a new transaction. IDLE samples that cycle's value.
- Simultaneous `w_m_ack` and reset: reset wins. No oe pulse, no count.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin on conflict only.
  - A 1-bit pointer records the last granted port.
  - When both request in IDLE, the port not last granted wins.
  - The pointer updates on every grant.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority; the data port always wins a conflict.
  - No pointer register.
  - Fetch can starve under continuous data traffic. This is acceptable because a stalled pipeline stops issuing memory ops.

## Test plan
- **Reset values:** drive `w_rst_n`=0 for 2 cycles, then release. All outputs are 0 and the FSM is in IDLE.
- **Single fetch:** fetch-only request at `w_i_addr`=0x00000010 with a k=1 memory returning 0x00500093.
  - `w_m_req` rises 1 cycle after the request.
  - `w_i_oe` pulses at t+3 with `w_i_rdata`=0x00500093.
  - `w_i_cnt`=1.
- **Store then load, same address:**
  - Store 0xDEADBEEF to 0x100: `w_d_oe` pulses and `w_d_rdata`=0.
  - Load from 0x100: `w_d_rdata`=0xDEADBEEF.
  - `w_m_we` is 1 only during the store's WAIT.
- **Conflict:** both ports request continuously for 4 transactions.
  - Fixed priority: D,D,D,D granted.
  - `MEM_ARB_RR_EN`: D,I,D,I granted.
  - `w_i_cnt` and `w_d_cnt` match each grant sequence.
- **Reset mid-operation:** with k=5, assert reset during WAIT and send ack 2 cycles after release.
  - No `*_oe` pulse.
  - Counters stay 0.
  - FSM stays in IDLE.
- **Back-to-back fetch:** PC+4 fetches with k=1. Consecutive `w_i_oe` pulses are exactly 4 cycles apart.
